// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory-ready stalls, wait timeout and illegal-opcode trap.
// Define MC_JUMP_EN to decode j (opcode 000010) through the JUMP state.
module multicycle_controller #(
    parameter int unsigned ALUOP_W = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               mem_write,
    output logic               illegal_op,
    output logic               mem_timeout,
    output logic [3:0]         state
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11,
        StTrap    = 4'd12
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            wait_st;
    logic            tmo_hit;

    assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // The wait that would bring the count to TIMEOUT traps; a ready in that cycle wins.
    assign tmo_hit = (TIMEOUT != 0) && wait_st && !mem_ready
                     && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));
    assign state   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            cnt_q       <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            // Wait states only exit on mem_ready, so any exit also clears the count.
            cnt_q <= (wait_st && !mem_ready) ? cnt_q + 1'b1 : '0;
            if (tmo_hit) begin
                state_q     <= StTrap;
                mem_timeout <= 1'b1;
            end else begin
                case (state_q)
                    StFetch:   if (mem_ready) state_q <= StDecode;
                    StDecode: begin
                        case (opcode)
                            OpLw, OpSw: state_q <= StMemAdr;
                            OpRtype:    state_q <= StExecute;
                            OpBeq:      state_q <= StBranch;
                            OpAddi:     state_q <= StAddiEx;
`ifdef MC_JUMP_EN
                            OpJ:        state_q <= StJump;
`endif
                            default: begin
                                state_q    <= StTrap;
                                illegal_op <= 1'b1;
                            end
                        endcase
                    end
                    StMemAdr:  state_q <= (opcode == OpSw) ? StMemWr : StMemRd;
                    StMemRd:   if (mem_ready) state_q <= StMemWb;
                    StMemWb:   state_q <= StFetch;
                    StMemWr:   if (mem_ready) state_q <= StFetch;
                    StExecute: state_q <= StAluWb;
                    StAluWb:   state_q <= StFetch;
                    StBranch:  state_q <= StFetch;
                    StAddiEx:  state_q <= StAddiWb;
                    StAddiWb:  state_q <= StFetch;
`ifdef MC_JUMP_EN
                    StJump:    state_q <= StFetch;
`endif
                    StTrap:    state_q <= StTrap;
                    default:   state_q <= StTrap;
                endcase
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = '0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode:  alu_src_b = 2'b11;
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            StExecute: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(2'b10);
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(2'b01);
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StAddiWb:  reg_write = 1'b1;
`ifdef MC_JUMP_EN
            StJump: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
`endif
            default: ;
        endcase
        if (rst) begin
            mem_req   = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            branch    = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction state-path model plus per-cycle compare.
module tb_multicycle_controller;

    localparam int unsigned AW  = 3;
    localparam int unsigned TMO = 4;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11;
    localparam logic [3:0] S_TRAP = 4'd12;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = 6'd0;
    logic          mem_ready = 1'b0;
    logic          mem_req, iord, ir_write, pc_write, branch;
    logic [1:0]    pc_src;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [AW-1:0] alu_op;
    logic          reg_write, reg_dst, mem_to_reg, mem_write, illegal_op, mem_timeout;
    logic [3:0]    state;

    multicycle_controller #(.ALUOP_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .branch(branch), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       ill;
        logic       tmo;
    } step_t;

    int    checks = 0;
    int    failures = 0;
    step_t q[$];
    step_t cur;
    logic  chk_en = 1'b0;
    logic  cur_rst = 1'b0;
    logic  m_ill = 1'b0;
    logic  m_tmo = 1'b0;
    int    cyc;

    wire [16:0] got_outs = {mem_req, iord, ir_write, pc_write, branch, pc_src, alu_src_a,
                            alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, mem_write};
    wire [5:0]  got_strobes = {mem_req, ir_write, pc_write, branch, reg_write, mem_write};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Output table straight from the per-state output list; unlisted outputs are 0.
    function automatic logic [16:0] exp_out(input logic [3:0] st, input logic rdy);
        logic mreq, io, irw, pcw, br, asa, rw, rd, m2r, mw;
        logic [1:0] ps, asb;
        logic [2:0] aop;
        {mreq, io, irw, pcw, br, asa, rw, rd, m2r, mw} = '0;
        ps = 2'b00; asb = 2'b00; aop = 3'b000;
        case (st)
            S_FETCH:  begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE: asb = 2'b11;
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mreq = 1; io = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mreq = 1; io = 1; mw = 1; end
            S_EXEC:   begin asa = 1; aop = 3'b010; end
            S_ALUWB:  begin rw = 1; rd = 1; end
            S_BRANCH: begin asa = 1; aop = 3'b001; ps = 2'b01; br = 1; end
            S_ADDIEX: begin asa = 1; asb = 2'b10; end
            S_ADDIWB: rw = 1;
            S_JUMP:   begin ps = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {mreq, io, irw, pcw, br, ps, asa, asb, aop, rw, rd, m2r, mw};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (cur_rst) begin
                check("reset_strobes", 32'(got_strobes), 32'd0);
            end else begin
                check("state", 32'(state), 32'(cur.st));
                check("outputs", 32'(got_outs), 32'(exp_out(cur.st, cur.rdy)));
                check("illegal_op", 32'(illegal_op), 32'(cur.ill));
                check("mem_timeout", 32'(mem_timeout), 32'(cur.tmo));
            end
        end
    end

    task automatic push(input logic [3:0] st, input logic rdy);
        step_t e;
        e.st = st; e.rdy = rdy; e.ill = m_ill; e.tmo = m_tmo;
        q.push_back(e);
    endtask

    // Expected state path of one instruction: fl/ml = low-ready cycles in fetch/memory wait.
    task automatic build(input logic [5:0] op, input int fl, input int ml, input int hold);
        q.delete();
        if (fl >= int'(TMO)) begin
            repeat (TMO) push(S_FETCH, 1'b0);
            m_tmo = 1'b1;
            repeat (hold) push(S_TRAP, 1'b0);
            return;
        end
        repeat (fl) push(S_FETCH, 1'b0);
        push(S_FETCH, 1'b1);
        push(S_DECODE, 1'b1);
        case (op)
            OP_R:    begin push(S_EXEC, 1'b1); push(S_ALUWB, 1'b1); end
            OP_LW: begin
                push(S_MEMADR, 1'b1);
                repeat (ml) push(S_MEMRD, 1'b0);
                push(S_MEMRD, 1'b1);
                push(S_MEMWB, 1'b1);
            end
            OP_SW: begin
                push(S_MEMADR, 1'b1);
                repeat (ml) push(S_MEMWR, 1'b0);
                push(S_MEMWR, 1'b1);
            end
            OP_BEQ:  push(S_BRANCH, 1'b1);
            OP_ADDI: begin push(S_ADDIEX, 1'b1); push(S_ADDIWB, 1'b1); end
`ifdef MC_JUMP_EN
            OP_J:    push(S_JUMP, 1'b1);
`endif
            default: begin
                m_ill = 1'b1;
                repeat (hold) push(S_TRAP, 1'b0);
            end
        endcase
    endtask

    task automatic play(input int limit);
        step_t e;
        int n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            e = q.pop_front();
            @(posedge clk);
            #1;
            rst = 1'b0; cur_rst = 1'b0; mem_ready = e.rdy; cur = e; chk_en = 1'b1;
            n++;
        end
        q.delete();
    endtask

    task automatic run(input logic [5:0] op, input int fl, input int ml, input int hold,
                       output int c);
        opcode = op;
        build(op, fl, ml, hold);
        c = q.size();
        play(1000);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; cur_rst = 1'b1; chk_en = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ill = 1'b0; m_tmo = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        run(OP_R, 0, 0, 0, cyc);    check("cpi_rtype", cyc, 4);
        run(OP_LW, 0, 3, 0, cyc);   check("cpi_lw_3wait", cyc, 8);
        run(OP_SW, 0, 0, 0, cyc);   check("cpi_sw", cyc, 4);
        run(OP_BEQ, 0, 0, 0, cyc);  check("cpi_beq", cyc, 3);
        run(OP_ADDI, 0, 0, 0, cyc); check("cpi_addi", cyc, 4);
        run(OP_SW, 2, 1, 0, cyc);   check("cpi_sw_waits", cyc, 7);
        run(OP_LW, 0, 0, 0, cyc);   check("cpi_lw", cyc, 5);

`ifdef MC_JUMP_EN
        run(OP_J, 0, 0, 0, cyc);    check("cpi_j", cyc, 3);
`else
        run(OP_J, 0, 0, 4, cyc);
        check("j_traps_illegal", 32'(illegal_op), 32'd1);
        check("j_trap_state", 32'(state), 32'd12);
        do_reset();
`endif

        run(OP_BAD, 0, 0, 20, cyc);
        check("illegal_flag", 32'(illegal_op), 32'd1);
        check("illegal_state", 32'(state), 32'd12);
        do_reset();
        run(OP_R, 0, 0, 0, cyc);

        run(OP_R, 4, 0, 5, cyc);
        check("timeout_flag", 32'(mem_timeout), 32'd1);
        check("timeout_no_illegal", 32'(illegal_op), 32'd0);
        check("timeout_state", 32'(state), 32'd12);
        do_reset();

        run(OP_R, 3, 0, 0, cyc);    check("cpi_ready_at_limit", cyc, 7);

        // Abandon an R-type in EXECUTE; its ALUWB cycle lands under reset.
        opcode = OP_R;
        build(OP_R, 0, 0, 0);
        play(3);
        do_reset();
        run(OP_ADDI, 1, 0, 0, cyc); check("cpi_addi_after_abort", cyc, 5);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
